hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard unit: load-use and branch-operand stalls, branch comparator forwarding, redirect flush.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] IDInstruction,
  input  logic        IDValid,
  input  logic        PCSrc,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushE,
  output logic        FlushD,
  output logic [1:0]  ForwardD,
  output logic [1:0]  ForwardE,
  output logic [1:0]  StallReason,
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount
);
  // Handshake-free block: all inputs describe the instruction sitting in decode this cycle;
  // stall/flush outputs are combinational and act on the next rising edge.

  typedef struct packed {
    logic [4:0] dst;
    logic       regwrite;
    logic       memread;
  } rec_t;

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_LOAD_USE   = 2'd1,
    S_BRANCH_DEP = 2'd2
  } state_t;

  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd;
  logic       use_rs, use_rt, is_br, is_ld, wr_rd, wr_rt;
  logic [4:0] wdst;
  rec_t       id_rec;
  rec_t       ex_q, ex_d, mem_q;
  state_t     state_q, state_d;
  logic       rs_ex, rt_ex, load_use, br_dep, stall;
  logic       unused_shamt;

  assign op = IDInstruction[31:26];
  assign rs = IDInstruction[25:21];
  assign rt = IDInstruction[20:16];
  assign rd = IDInstruction[15:11];
  assign fn = IDInstruction[5:0];
  assign unused_shamt = ^IDInstruction[10:6];

  always_comb begin
    use_rs = 1'b0;
    use_rt = 1'b0;
    is_br  = 1'b0;
    is_ld  = 1'b0;
    wr_rd  = 1'b0;
    wr_rt  = 1'b0;
    case (op)
      6'h00: begin
        case (fn)
          6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A: begin
            use_rs = 1'b1;
            use_rt = 1'b1;
            wr_rd  = 1'b1;
          end
          6'h00, 6'h02, 6'h03: begin
            use_rt = 1'b1;
            wr_rd  = 1'b1;
          end
          6'h08: begin
            use_rs = 1'b1;
            is_br  = 1'b1;
          end
          default: ;
        endcase
      end
      6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A: begin
        use_rs = 1'b1;
        wr_rt  = 1'b1;
      end
      6'h0F: wr_rt = 1'b1;
      6'h23: begin
        use_rs = 1'b1;
        wr_rt  = 1'b1;
        is_ld  = 1'b1;
      end
      6'h2B: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      6'h04, 6'h05: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
        is_br  = 1'b1;
      end
      default: ;
    endcase
  end

  // $zero and $ra never count as producers ($ra is written by JAL in decode).
  always_comb begin
    wdst = wr_rd ? rd : (wr_rt ? rt : 5'd0);
    id_rec.regwrite = (wr_rd | wr_rt) & (wdst != 5'd0) & (wdst != 5'd31);
    id_rec.dst      = id_rec.regwrite ? wdst : 5'd0;
    id_rec.memread  = is_ld & id_rec.regwrite;
  end

  function automatic logic hit(input logic [4:0] s, input rec_t r);
    return r.regwrite && (r.dst == s) && (s != 5'd0);
  endfunction

  assign rs_ex    = use_rs & hit(rs, ex_q);
  assign rt_ex    = use_rt & hit(rt, ex_q);
  assign load_use = IDValid & ~is_br & ex_q.memread & (rs_ex | rt_ex);
  assign br_dep   = IDValid & is_br & (rs_ex | rt_ex);
  assign stall    = load_use | br_dep;

  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall;
  assign FlushD = PCSrc & ~stall & ~Rst;

  always_comb begin
    ForwardD = 2'd0;
    ForwardE = 2'd0;
    if (IDValid && is_br && use_rs && hit(rs, mem_q)) ForwardD = mem_q.memread ? 2'd2 : 2'd1;
    if (IDValid && is_br && use_rt && hit(rt, mem_q)) ForwardE = mem_q.memread ? 2'd2 : 2'd1;
  end

  always_comb begin
    ex_d = (stall || !IDValid) ? '0 : id_rec;
    state_d = S_RUN;
    if (br_dep)        state_d = S_BRANCH_DEP;
    else if (load_use) state_d = S_LOAD_USE;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      state_q <= S_RUN;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      state_q <= state_d;
    end
  end

  assign StallReason = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (stall && stall_cnt_q != 16'hFFFF)  stall_cnt_q <= stall_cnt_q + 16'd1;
      if (FlushD && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`else
  assign StallCount = 16'd0;
  assign FlushCount = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus randomized decode
// stream checked every cycle against an instruction-history model.
module tb_hazard_ctrl;
  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] IDInstruction = 32'd0;
  logic        IDValid = 1'b0;
  logic        PCSrc = 1'b0;
  logic        StallF, StallD, FlushE, FlushD;
  logic [1:0]  ForwardD, ForwardE, StallReason;
  logic [15:0] StallCount, FlushCount;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  hazard_ctrl dut (
    .Clk(Clk), .Rst(Rst), .IDInstruction(IDInstruction), .IDValid(IDValid), .PCSrc(PCSrc),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .FlushD(FlushD),
    .ForwardD(ForwardD), .ForwardE(ForwardE), .StallReason(StallReason),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 Clk = ~Clk;

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] r_ins(input int fn, input int rs, input int rt, input int rd);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
  endfunction
  function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  localparam int T0 = 8, T1 = 9, T2 = 10, T3 = 11, S0 = 16, S1 = 17, A0 = 4;
  localparam logic [31:0] NOP = 32'd0;

  // ---------------- behavioural model ----------------
  typedef struct {
    bit us, ut, br, ld;
    int rs, rt, dst;
  } dec_t;

  typedef struct {
    bit stall, bd;
    int fd, fe;
    bit flushd;
  } exp_t;

  // Each entry: register written (0 = none) and whether it is a load.
  int m_ex_dst, m_mem_dst;
  bit m_ex_ld, m_mem_ld;
  int m_reason, m_scnt, m_fcnt;

  function automatic dec_t dec(input logic [31:0] ins);
    dec_t d;
    int op, fn, wd;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    d.us = 0; d.ut = 0; d.br = 0; d.ld = 0;
    d.rs = int'(ins[25:21]);
    d.rt = int'(ins[20:16]);
    wd = 0;
    if (op == 0) begin
      if (fn inside {'h20, 'h22, 'h24, 'h25, 'h26, 'h27, 'h2A}) begin d.us = 1; d.ut = 1; wd = int'(ins[15:11]); end
      else if (fn inside {0, 2, 3}) begin d.ut = 1; wd = int'(ins[15:11]); end
      else if (fn == 'h08) begin d.us = 1; d.br = 1; end
    end else if (op inside {'h08, 'h0C, 'h0D, 'h0E, 'h0A}) begin d.us = 1; wd = d.rt; end
    else if (op == 'h0F) wd = d.rt;
    else if (op == 'h23) begin d.us = 1; d.ld = 1; wd = d.rt; end
    else if (op == 'h2B) begin d.us = 1; d.ut = 1; end
    else if (op inside {'h04, 'h05}) begin d.us = 1; d.ut = 1; d.br = 1; end
    d.dst = (wd == 0 || wd == 31) ? 0 : wd;
    if (d.dst == 0) d.ld = 0;
    return d;
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input bit v, input bit pc, input bit rst);
    exp_t e;
    dec_t d;
    int s0, s1;
    bit ex_hit;
    d = dec(ins);
    s0 = d.us ? d.rs : 0;
    s1 = d.ut ? d.rt : 0;
    ex_hit = (s0 != 0 && s0 == m_ex_dst) || (s1 != 0 && s1 == m_ex_dst);
    e.bd    = v && d.br && ex_hit;
    e.stall = e.bd || (v && !d.br && m_ex_ld && ex_hit);
    e.fd = (v && d.br && s0 != 0 && s0 == m_mem_dst) ? (m_mem_ld ? 2 : 1) : 0;
    e.fe = (v && d.br && s1 != 0 && s1 == m_mem_dst) ? (m_mem_ld ? 2 : 1) : 0;
    e.flushd = pc && !e.stall && !rst;
    return e;
  endfunction

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      m_ex_dst <= 0; m_ex_ld <= 0; m_mem_dst <= 0; m_mem_ld <= 0;
      m_reason <= 0; m_scnt <= 0; m_fcnt <= 0;
    end else begin
      exp_t e;
      dec_t d;
      e = model(IDInstruction, IDValid, PCSrc, 1'b0);
      d = dec(IDInstruction);
      m_mem_dst <= m_ex_dst;
      m_mem_ld  <= m_ex_ld;
      m_ex_dst  <= (e.stall || !IDValid) ? 0 : d.dst;
      m_ex_ld   <= (e.stall || !IDValid) ? 0 : d.ld;
      m_reason  <= e.stall ? (e.bd ? 2 : 1) : 0;
      if (e.stall && m_scnt != 'hFFFF)  m_scnt <= m_scnt + 1;
      if (e.flushd && m_fcnt != 'hFFFF) m_fcnt <= m_fcnt + 1;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  bit dut_prev_stall = 0;

  always @(negedge Clk) begin
    if (cmp_en) begin
      exp_t e;
      e = model(IDInstruction, IDValid, PCSrc, Rst);
      chk("cmp_stallf", int'(StallF), int'(e.stall));
      chk("cmp_stalld", int'(StallD), int'(e.stall));
      chk("cmp_flushe", int'(FlushE), int'(e.stall));
      chk("cmp_flushd", int'(FlushD), int'(e.flushd));
      chk("cmp_fwd_d", int'(ForwardD), e.fd);
      chk("cmp_fwd_e", int'(ForwardE), e.fe);
      chk("cmp_reason", int'(StallReason), m_reason);
`ifdef HAZARD_PERF_CNT_EN
      chk("cmp_stallcnt", int'(StallCount), m_scnt);
      chk("cmp_flushcnt", int'(FlushCount), m_fcnt);
`else
      chk("cmp_stallcnt", int'(StallCount), 0);
      chk("cmp_flushcnt", int'(FlushCount), 0);
`endif
      if (StallD) chk("no_back_to_back_stall", int'(dut_prev_stall), 0);
      dut_prev_stall = Rst ? 1'b0 : StallD;
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic [31:0] ins, input bit v = 1'b1, input bit pc = 1'b0);
    @(posedge Clk);
    #1;
    IDInstruction = ins;
    IDValid = v;
    PCSrc = pc;
  endtask

  task automatic settle();
    drive(NOP); drive(NOP); drive(NOP);
  endtask

  function automatic logic [31:0] rand_ins();
    int regs[5] = '{0, T0, T1, T2, 31};
    int a, b, c;
    a = regs[$urandom_range(0, 4)];
    b = regs[$urandom_range(0, 4)];
    c = regs[$urandom_range(0, 4)];
    case ($urandom_range(0, 13))
      0:  return r_ins('h20, a, b, c);
      1:  return r_ins('h2A, a, b, c);
      2:  return r_ins('h02, 0, b, c);
      3:  return r_ins('h08, a, 0, 0);
      4:  return i_ins('h08, a, b, 4);
      5:  return i_ins('h0F, 0, b, 1);
      6, 7: return i_ins('h23, a, b, 8);
      8:  return i_ins('h2B, a, b, 0);
      9, 10: return i_ins('h04, a, b, 2);
      11: return i_ins('h05, a, b, 2);
      12: return {6'h02, 26'd100};
      default: return {6'h03, 26'd100};
    endcase
  endfunction

  initial begin
    logic [31:0] cur;
    #3;
    chk("reset_stall", int'(StallD), 0);
    chk("reset_flushd", int'(FlushD), 0);
    chk("reset_fwd", int'({ForwardD, ForwardE}), 0);
    chk("reset_reason", int'(StallReason), 0);
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    cmp_en = 1'b1;
    settle();

    // Load-use: one stall cycle, reason visible the cycle after.
    drive(i_ins('h23, S0, T0, 0));
    drive(r_ins('h20, T0, T2, T1));
    @(negedge Clk);
    chk("lu_stall", int'({StallF, StallD, FlushE}), 7);
    drive(r_ins('h20, T0, T2, T1));
    @(negedge Clk);
    chk("lu_release", int'(StallD), 0);
    chk("lu_reason", int'(StallReason), 1);
    drive(NOP);
    @(negedge Clk);
    chk("lu_reason_run", int'(StallReason), 0);
    settle();

    // ALU producer feeding a branch: stall then MEM forward on rs.
    drive(r_ins('h20, T1, T2, T0));
    drive(i_ins('h04, T0, T1, 3));
    @(negedge Clk);
    chk("bd_stall", int'(StallD), 1);
    drive(i_ins('h04, T0, T1, 3));
    @(negedge Clk);
    chk("bd_release", int'(StallD), 0);
    chk("bd_fwd_d", int'(ForwardD), 1);
    chk("bd_fwd_e", int'(ForwardE), 0);
    chk("bd_reason", int'(StallReason), 2);
    settle();

    // Load two ahead of branch: load-data forward on rt, no stall.
    drive(i_ins('h23, A0, S1, 4));
    drive(NOP);
    drive(i_ins('h05, T3, S1, 3));
    @(negedge Clk);
    chk("ld_br_stall", int'(StallD), 0);
    chk("ld_br_fwd_e", int'(ForwardE), 2);
    chk("ld_br_fwd_d", int'(ForwardD), 0);
    settle();

    // Writes to $zero never create a dependency.
    drive(r_ins('h20, T1, T2, 0));
    drive(i_ins('h04, 0, T1, 3));
    @(negedge Clk);
    chk("zero_stall", int'(StallD), 0);
    chk("zero_fwd", int'({ForwardD, ForwardE}), 0);
    settle();

    // Redirect flush, and stall taking priority over it.
    drive({6'h02, 26'd64}, 1'b1, 1'b1);
    @(negedge Clk);
    chk("jump_flushd", int'(FlushD), 1);
    drive(r_ins('h20, T1, T2, T0));
    drive(i_ins('h04, T0, T1, 3), 1'b1, 1'b1);
    @(negedge Clk);
    chk("prio_stall", int'(StallD), 1);
    chk("prio_flushd", int'(FlushD), 0);
    drive(i_ins('h04, T0, T1, 3), 1'b1, 1'b1);
    @(negedge Clk);
    chk("prio_flushd_after", int'(FlushD), 1);
    settle();

    // Bubble in decode: no hazard, flush still follows the redirect.
    drive(i_ins('h23, S0, T0, 0));
    drive(r_ins('h20, T0, T2, T1), 1'b0, 1'b1);
    @(negedge Clk);
    chk("bubble_stall", int'(StallD), 0);
    chk("bubble_flushd", int'(FlushD), 1);
    settle();

    // Asynchronous reset in the middle of a load-use stall.
    drive(i_ins('h23, S0, T0, 0));
    drive(r_ins('h20, T0, T2, T1), 1'b1, 1'b1);
    #2;
    chk("rst_pre_stall", int'(StallD), 1);
    Rst = 1'b1;
    #1;
    chk("rst_stall", int'({StallF, StallD, FlushE}), 0);
    chk("rst_flushd", int'(FlushD), 0);
    chk("rst_fwd", int'({ForwardD, ForwardE}), 0);
    chk("rst_reason", int'(StallReason), 0);
    chk("rst_counts", int'({StallCount, FlushCount}), 0);
    @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    chk("rst_add_no_stall", int'(StallD), 0);
    settle();

    // Randomized stream; a stalled instruction stays in decode.
    cur = rand_ins();
    for (int i = 0; i < 600; i++) begin
      exp_t e;
      bit v, pc;
      e = model(IDInstruction, IDValid, PCSrc, 1'b0);
      if (!e.stall) cur = rand_ins();
      v  = ($urandom_range(0, 9) != 0);
      pc = ($urandom_range(0, 3) == 0);
      if (e.stall) v = 1'b1;
      drive(cur, v, pc);
    end
    drive(NOP);
    @(negedge Clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
